spi_frame_fsm: RTL and testbench
================================

// Module: spi_frame_fsm
// PURPOSE
//  Control FSM downstream of the input conditioners and shift register in the SPI
//  memory path. Consumes conditioned chip-select, SCLK edge pulses and the shift
//  register's parallel output, and decodes one framed transaction per CS-low window:
//  address byte (7-bit addr + R/W bit), then one data byte in or out.
//  Drives: address latch, data-memory write strobe, shift-register parallel load,
//  MISO tri-state enable.
// PARAMETERS
//  WIDTH   8   bits per byte; address = WIDTH-1 bits; bit counter sized for 0..WIDTH
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  reset        in   1        synchronous, active-high
//  cs           in   1        conditioned chip select, active-low (1 = deselected)
//  sclk_pe      in   1        one-cycle pulse, SCLK rising edge (from conditioner)
//  sclk_ne      in   1        one-cycle pulse, SCLK falling edge (from conditioner)
//  sr_q         in   WIDTH    shift register parallel out; sr_q[0] = most recent bit
//  addr         out  WIDTH-1  latched transaction address
//  dm_we        out  1        data-memory write enable, one-cycle pulse
//  sr_load      out  1        shift-register parallel load, one-cycle pulse
//  miso_en      out  1        MISO output buffer enable
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, bit count 0, rw 0, addr 0; dm_we, sr_load, miso_en, busy 0.
//  - Moore outputs decoded from the state register; addr is a register.
//  - States:
//    IDLE -> GET_ADDR when cs==0 (count cleared).
//    GET_ADDR: count++ per sclk_pe; count==WIDTH -> GOT_ADDR.
//    GOT_ADDR: addr <= sr_q[WIDTH-1:1], rw <= sr_q[0], count <= 0;
//      -> READ_LOAD if sr_q[0]==1, else WRITE_GET.
//    READ_LOAD: sr_load=1 (exactly 1 cycle; memory read is combinational on addr)
//      -> READ_SEND.
//    READ_SEND: miso_en=1; count++ per sclk_ne; count==WIDTH -> DONE.
//    WRITE_GET: count++ per sclk_pe; count==WIDTH -> WRITE_STORE.
//    WRITE_STORE: dm_we=1 (exactly 1 cycle) -> DONE.
//    DONE: all strobes 0, sclk pulses ignored; leave only via cs==1 -> IDLE.
//  - Timing (cycle T carries the WIDTH-th sclk_pe of the address byte):
//    GOT_ADDR in T+2; addr valid and sr_load high in T+3; miso_en from T+4.
//    Write: dm_we high in cycle T+2, T = cycle of WIDTH-th data sclk_pe.
//  - cs==1 in any state (except while reset is asserted): next state IDLE, count 0,
//    all strobes 0 next cycle. addr holds its last value.
//    An aborted write never asserts dm_we.
//  - Only the edge relevant to the current state is counted.
//    sclk_pe is ignored in READ_SEND; sclk_ne is ignored elsewhere.
//    If both pulses arrive in the same cycle, the relevant one alone counts.
//  - Count saturates at WIDTH and never wraps; an edge arriving in the transition
//    cycle is dropped.
//  - reset has priority over every other input.
// TESTING
//  1 Write: cs=0, shift 0x54 (addr 0x2A, rw 0) then 0xC3
//    -> addr=0x2A; dm_we high exactly 1 cycle at T+2;
//       sr_load and miso_en stay 0; DONE until cs=1.
//  2 Read: cs=0, shift 0x55 (addr 0x2A, rw 1)
//    -> sr_load high exactly cycle T+3 with addr=0x2A;
//       miso_en 1 from T+4 through the 8th sclk_ne, then 0.
//  3 Abort: write frame, raise cs after 5 data bits
//    -> dm_we never asserts; busy=0 next cycle; next frame decodes normally.
//  4 Reset mid READ_SEND after 3 sclk_ne
//    -> next cycle miso_en=0, busy=0, addr=0.
//  5 DONE hold: 8 extra sclk pulse pairs with cs held 0 after a write
//    -> no dm_we, sr_load or miso_en; cs 1->0 starts a fresh frame.
//  6 Back-to-back: two frames (write 0x10 <- 0xAA, read 0x10), cs high 2 cycles between
//    -> both decoded; addr=0x10 both times.

Source files
------------

// File: rtl/spi_frame_fsm.sv
// -----------------------------------------------------------------------------
// spi_frame_fsm
// Control FSM for the SPI memory path. Decodes one framed transaction per
// chip-select-low window: an address byte (WIDTH-1 address bits + R/W bit in
// the LSB), followed by one data byte shifted in (write) or out (read).
//
// Ports
//   clk      in   1        system clock, all logic on posedge
//   reset    in   1        synchronous, active-high
//   cs       in   1        conditioned chip select, active-low
//   sclk_pe  in   1        one-cycle pulse on SCLK rising edge
//   sclk_ne  in   1        one-cycle pulse on SCLK falling edge
//   sr_q     in   WIDTH    shift register parallel out, sr_q[0] = newest bit
//   addr     out  WIDTH-1  latched transaction address
//   dm_we    out  1        data-memory write strobe (one cycle)
//   sr_load  out  1        shift-register parallel load strobe (one cycle)
//   miso_en  out  1        MISO output buffer enable
//   busy     out  1        FSM not idle
// -----------------------------------------------------------------------------
module spi_frame_fsm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk_pe,
    input  logic             sclk_ne,
    input  logic [WIDTH-1:0] sr_q,
    output logic [WIDTH-2:0] addr,
    output logic             dm_we,
    output logic             sr_load,
    output logic             miso_en,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] IDLE        = 3'd0;
    localparam logic [SW-1:0] GET_ADDR    = 3'd1;
    localparam logic [SW-1:0] GOT_ADDR    = 3'd2;
    localparam logic [SW-1:0] READ_LOAD   = 3'd3;
    localparam logic [SW-1:0] READ_SEND   = 3'd4;
    localparam logic [SW-1:0] WRITE_GET   = 3'd5;
    localparam logic [SW-1:0] WRITE_STORE = 3'd6;
    localparam logic [SW-1:0] DONE        = 3'd7;

    localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    logic [SW-1:0]    state;
    logic [SW-1:0]    state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             rw;
    logic             rw_next;
    logic [WIDTH-2:0] addr_next;
    logic             dm_we_next;
    logic             sr_load_next;
    logic             miso_en_next;
    logic             busy_next;

    // State, counter, address and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            rw      <= 1'b0;
            addr    <= '0;
            dm_we   <= 1'b0;
            sr_load <= 1'b0;
            miso_en <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            rw      <= rw_next;
            addr    <= addr_next;
            dm_we   <= dm_we_next;
            sr_load <= sr_load_next;
            miso_en <= miso_en_next;
            busy    <= busy_next;
        end
    end

    // Next-state logic. The count only advances on the edge that matters in
    // the current state and stops at WIDTH; the cycle that sees a full count
    // is the transition cycle, so any edge arriving then is dropped.
    always_comb begin
        state_next = state;
        count_next = count;
        rw_next    = rw;
        addr_next  = addr;

        if (cs) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = GET_ADDR;
                    count_next = '0;
                end
                GET_ADDR: begin
                    if (count == COUNT_FULL) begin
                        state_next = GOT_ADDR;
                    end else if (sclk_pe) begin
                        count_next = count + COUNT_ONE;
                    end
                end
                GOT_ADDR: begin
                    addr_next  = sr_q[WIDTH-1:1];
                    rw_next    = sr_q[0];
                    count_next = '0;
                    state_next = sr_q[0] ? READ_LOAD : WRITE_GET;
                end
                READ_LOAD: begin
                    state_next = READ_SEND;
                end
                READ_SEND: begin
                    if (count == COUNT_FULL) begin
                        state_next = DONE;
                    end else if (sclk_ne) begin
                        count_next = count + COUNT_ONE;
                    end
                end
                WRITE_GET: begin
                    if (count == COUNT_FULL) begin
                        state_next = WRITE_STORE;
                    end else if (sclk_pe) begin
                        count_next = count + COUNT_ONE;
                    end
                end
                WRITE_STORE: begin
                    state_next = DONE;
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Moore outputs, registered from the next state so they line up with it.
    always_comb begin
        dm_we_next   = 1'b0;
        sr_load_next = 1'b0;
        miso_en_next = 1'b0;
        busy_next    = 1'b0;
        dm_we_next   = (state_next == WRITE_STORE);
        sr_load_next = (state_next == READ_LOAD);
        miso_en_next = (state_next == READ_SEND);
        busy_next    = (state_next != IDLE);
    end

endmodule

// File: tb/tb_spi_frame_fsm.sv
module tb_spi_frame_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       sclk_pe;
    logic       sclk_ne;
    logic [7:0] sr_q;
    logic [6:0] addr;
    logic       dm_we;
    logic       sr_load;
    logic       miso_en;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Strobe activity recorded at the falling edge.
    int         n_we = 0, n_ld = 0, n_mi = 0;
    int         we_cyc = 0, ld_cyc = 0, mi_first = 0, mi_last = 0;
    logic [6:0] ld_addr = '0;
    logic       mi_prev = 1'b0;

    typedef struct {
        int         we;
        int         we_cyc;
        int         ld;
        int         ld_cyc;
        int         mi;
        int         mi_first;
        int         mi_last;
        logic [6:0] addr;
    } exp_t;

    spi_frame_fsm #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .sclk_pe (sclk_pe),
        .sclk_ne (sclk_ne),
        .sr_q    (sr_q),
        .addr    (addr),
        .dm_we   (dm_we),
        .sr_load (sr_load),
        .miso_en (miso_en),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dm_we) begin
            n_we++;
            we_cyc = cyc;
        end
        if (sr_load) begin
            n_ld++;
            ld_cyc  = cyc;
            ld_addr = addr;
        end
        if (miso_en) begin
            n_mi++;
            if (!mi_prev) mi_first = cyc;
            mi_last = cyc;
        end
        mi_prev = miso_en;
    end

    // Frame-level reference: what a complete or truncated frame must produce.
    // t_addr = cycle of 8th address rising edge; t_last = cycle of the last
    // data edge that matters (rising for writes, falling for reads).
    function automatic exp_t model(input logic [7:0] ab, input int nbits,
                                   input int t_addr, input int t_last);
        exp_t e;
        e = '{default: 0};
        e.addr = ab[7:1];
        if (ab[0]) begin
            e.ld     = 1;
            e.ld_cyc = t_addr + 3;
            if (nbits == 8) begin
                e.mi_first = t_addr + 4;
                e.mi_last  = t_last + 1;
                e.mi       = e.mi_last - e.mi_first + 1;
            end
        end else if (nbits == 8) begin
            e.we     = 1;
            e.we_cyc = t_last + 2;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SCLK period; the shift register takes the bit the cycle after the rising edge.
    task automatic send_bit(input logic b, input bit last_addr, input bit coinc,
                            output int pe_c, output int ne_c);
        if (coinc) begin
            sclk_pe = 1'b1;
            sclk_ne = 1'b1;
            pe_c    = cyc;
            ne_c    = cyc;
            tick();
            sclk_pe = 1'b0;
            sclk_ne = 1'b0;
            sr_q    = {sr_q[6:0], b};
        end else begin
            sclk_pe = 1'b1;
            pe_c    = cyc;
            tick();
            sclk_pe = 1'b0;
            sr_q    = {sr_q[6:0], b};
            if (!last_addr) repeat ($urandom_range(0, 2)) tick();
            sclk_ne = 1'b1;
            ne_c    = cyc;
            tick();
            sclk_ne = 1'b0;
        end
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic frame(input logic [7:0] ab, input logic [7:0] db, input int nbits,
                         output int t_addr, output int t_last);
        int p, n;
        p = 0;
        n = 0;
        t_addr = 0;
        cs = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        for (int i = 7; i >= 0; i--) begin
            send_bit(ab[i], i == 0, (i != 0) && ($urandom_range(0, 3) == 0), p, n);
            if (i == 0) t_addr = p;
        end
        tick();
        t_last = t_addr;
        for (int k = 0; k < nbits; k++) begin
            send_bit(db[7-k], 1'b0, $urandom_range(0, 3) == 0, p, n);
            t_last = ab[0] ? n : p;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        cs      = 1'b0;
        sclk_pe = 1'b0;
        sclk_ne = 1'b0;
        sr_q    = 8'h00;
        repeat (3) tick();
        tests++;
        if ({addr, dm_we, sr_load, miso_en, busy} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: addr=%h we=%b ld=%b mi=%b busy=%b, required all 0",
                     addr, dm_we, sr_load, miso_en, busy);
        end
        cs = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    // Full frame, then chip select released for gap cycles.
    task automatic test_frame(input logic [7:0] ab, input logic [7:0] db, input int gap);
        int   b_we, b_ld, b_mi, t_addr, t_last;
        exp_t e;
        b_we = n_we;
        b_ld = n_ld;
        b_mi = n_mi;
        frame(ab, db, 8, t_addr, t_last);
        repeat (6) tick();
        e = model(ab, 8, t_addr, t_last);
        tests++;
        if (n_we - b_we !== e.we || (e.we == 1 && we_cyc !== e.we_cyc)) begin
            fails++;
            $display("FAIL dm_we ab=%h: pulses=%0d at %0d, required %0d at %0d",
                     ab, n_we - b_we, we_cyc, e.we, e.we_cyc);
        end
        tests++;
        if (n_ld - b_ld !== e.ld || (e.ld == 1 && (ld_cyc !== e.ld_cyc || ld_addr !== e.addr))) begin
            fails++;
            $display("FAIL sr_load ab=%h: pulses=%0d at %0d addr=%h, required %0d at %0d addr=%h",
                     ab, n_ld - b_ld, ld_cyc, ld_addr, e.ld, e.ld_cyc, e.addr);
        end
        tests++;
        if (n_mi - b_mi !== e.mi || (e.mi != 0 && (mi_first !== e.mi_first || mi_last !== e.mi_last))) begin
            fails++;
            $display("FAIL miso_en ab=%h: cycles=%0d %0d..%0d, required %0d %0d..%0d",
                     ab, n_mi - b_mi, mi_first, mi_last, e.mi, e.mi_first, e.mi_last);
        end
        tests++;
        if (addr !== e.addr || busy !== 1'b1 || miso_en !== 1'b0) begin
            fails++;
            $display("FAIL done_state ab=%h: addr=%h busy=%b mi=%b, required addr=%h busy=1 mi=0",
                     ab, addr, busy, miso_en, e.addr);
        end
        cs = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL cs_release ab=%h: busy=%b required 0", ab, busy);
        end
        repeat (gap - 1) tick();
    endtask

    task automatic test_write();
        test_frame(8'h54, 8'hC3, 3);
    endtask

    task automatic test_read();
        test_frame(8'h55, 8'h00, 3);
    endtask

    task automatic test_random();
        repeat (8) test_frame(8'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
    endtask

    task automatic test_abort();
        int         b_we, t_addr, t_last;
        logic [7:0] ab;
        ab   = {7'($urandom), 1'b0};
        b_we = n_we;
        frame(ab, 8'($urandom), 5, t_addr, t_last);
        cs = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_busy: busy=%b required 0", busy);
        end
        repeat (6) tick();
        tests++;
        if (n_we - b_we !== 0 || addr !== ab[7:1]) begin
            fails++;
            $display("FAIL abort_we: pulses=%0d addr=%h, required 0 addr=%h",
                     n_we - b_we, addr, ab[7:1]);
        end
        test_frame(8'($urandom), 8'($urandom), 2);
    endtask

    task automatic test_reset_mid_read();
        int         t_addr, t_last;
        logic [7:0] ab;
        ab = {7'($urandom_range(1, 127)), 1'b1};
        frame(ab, 8'h00, 3, t_addr, t_last);
        tests++;
        if (miso_en !== 1'b1 || addr !== ab[7:1]) begin
            fails++;
            $display("FAIL mid_read: mi=%b addr=%h, required mi=1 addr=%h", miso_en, addr, ab[7:1]);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (miso_en !== 1'b0 || busy !== 1'b0 || addr !== 7'h00) begin
            fails++;
            $display("FAIL reset_mid_read: mi=%b busy=%b addr=%h, required 0 0 00",
                     miso_en, busy, addr);
        end
        reset = 1'b0;
        cs    = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_done_hold();
        int b_we, b_ld, b_mi, t_addr, t_last, p, n;
        frame({7'($urandom), 1'b0}, 8'($urandom), 8, t_addr, t_last);
        repeat (6) tick();
        b_we = n_we;
        b_ld = n_ld;
        b_mi = n_mi;
        for (int k = 0; k < 8; k++) send_bit(1'($urandom), 1'b0, $urandom_range(0, 3) == 0, p, n);
        tests++;
        if (n_we != b_we || n_ld != b_ld || n_mi != b_mi || busy !== 1'b1) begin
            fails++;
            $display("FAIL done_hold: we=%0d ld=%0d mi=%0d busy=%b, required 0 0 0 busy=1",
                     n_we - b_we, n_ld - b_ld, n_mi - b_mi, busy);
        end
        cs = 1'b1;
        repeat (2) tick();
        test_frame(8'($urandom), 8'($urandom), 2);
    endtask

    task automatic test_back_to_back();
        test_frame(8'h20, 8'hAA, 2);
        test_frame(8'h21, 8'h00, 2);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_mid_read();
        test_done_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
